// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: buffers ALU/MUL/LSU results in per-source FIFOs and
// broadcasts at most one per cycle, granted round-robin, through a registered CDB port.
module cdb_arbiter #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned TAG_W      = 5,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              alu_valid_i,
    input  logic [TAG_W-1:0]  alu_tag_i,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic              alu_ready_o,
    input  logic              mul_valid_i,
    input  logic [TAG_W-1:0]  mul_tag_i,
    input  logic [DATA_W-1:0] mul_data_i,
    output logic              mul_ready_o,
    input  logic              lsu_valid_i,
    input  logic [TAG_W-1:0]  lsu_tag_i,
    input  logic [DATA_W-1:0] lsu_data_i,
    output logic              lsu_ready_o,
    output logic              cdb_en_o,
    output logic [TAG_W-1:0]  cdb_tag_o,
    output logic [DATA_W-1:0] cdb_data_o,
    output logic [1:0]        cdb_src_o
);

    localparam int unsigned NSRC  = 3;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENT_W = TAG_W + DATA_W;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MUL = 2'd1,
        SRC_LSU = 2'd2
    } src_e;

    logic [ENT_W-1:0]  mem_q    [NSRC][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q [NSRC];
    logic [PTR_W-1:0]  rd_ptr_d [NSRC];
    logic [PTR_W-1:0]  wr_ptr_q [NSRC];
    logic [PTR_W-1:0]  wr_ptr_d [NSRC];
    logic [CNT_W-1:0]  count_q  [NSRC];
    logic [CNT_W-1:0]  count_d  [NSRC];
    logic [ENT_W-1:0]  in_ent   [NSRC];
    logic [NSRC-1:0]   in_valid;
    logic [NSRC-1:0]   ready;
    logic [NSRC-1:0]   enq;
    logic [NSRC-1:0]   deq;

    src_e              last_q, last_d;
    src_e              order [NSRC];
    src_e              grant_src;
    logic              grant_valid;
    logic [ENT_W-1:0]  head_ent;

    logic              cdb_en_q, cdb_en_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    src_e              cdb_src_q, cdb_src_d;

    assign in_valid  = {lsu_valid_i, mul_valid_i, alu_valid_i};
    assign in_ent[0] = {alu_tag_i, alu_data_i};
    assign in_ent[1] = {mul_tag_i, mul_data_i};
    assign in_ent[2] = {lsu_tag_i, lsu_data_i};

    // Ready reflects registered occupancy only; reset_i forces it low.
    always_comb begin
        for (int unsigned s = 0; s < NSRC; s++) begin
            ready[s] = !reset_i && (count_q[s] < CNT_W'(FIFO_DEPTH));
            enq[s]   = in_valid[s] && ready[s];
        end
    end

    assign alu_ready_o = ready[0];
    assign mul_ready_o = ready[1];
    assign lsu_ready_o = ready[2];

    always_comb begin
        case (last_q)
            SRC_ALU: order = '{SRC_MUL, SRC_LSU, SRC_ALU};
            SRC_MUL: order = '{SRC_LSU, SRC_ALU, SRC_MUL};
            default: order = '{SRC_ALU, SRC_MUL, SRC_LSU};
        endcase
        grant_valid = 1'b0;
        grant_src   = last_q;
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (!grant_valid && (count_q[order[k]] != '0)) begin
                grant_valid = 1'b1;
                grant_src   = order[k];
            end
        end
        deq = '0;
        if (grant_valid) begin
            deq[grant_src] = 1'b1;
        end
        head_ent = mem_q[grant_src][rd_ptr_q[grant_src]];
    end

    always_comb begin
        for (int unsigned s = 0; s < NSRC; s++) begin
            rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(deq[s]);
            wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(enq[s]);
            case ({enq[s], deq[s]})
                2'b10:   count_d[s] = count_q[s] + CNT_W'(1);
                2'b01:   count_d[s] = count_q[s] - CNT_W'(1);
                default: count_d[s] = count_q[s];
            endcase
        end
        last_d     = grant_valid ? grant_src : last_q;
        cdb_en_d   = grant_valid;
        cdb_tag_d  = cdb_tag_q;
        cdb_data_d = cdb_data_q;
        cdb_src_d  = cdb_src_q;
        if (grant_valid) begin
            cdb_tag_d  = head_ent[ENT_W-1:DATA_W];
            cdb_data_d = head_ent[DATA_W-1:0];
            cdb_src_d  = grant_src;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned s = 0; s < NSRC; s++) begin
                rd_ptr_q[s] <= '0;
                wr_ptr_q[s] <= '0;
                count_q[s]  <= '0;
            end
            last_q     <= SRC_LSU;
            cdb_en_q   <= 1'b0;
            cdb_tag_q  <= '0;
            cdb_data_q <= '0;
            cdb_src_q  <= SRC_ALU;
        end else begin
            for (int unsigned s = 0; s < NSRC; s++) begin
                rd_ptr_q[s] <= rd_ptr_d[s];
                wr_ptr_q[s] <= wr_ptr_d[s];
                count_q[s]  <= count_d[s];
            end
            last_q     <= last_d;
            cdb_en_q   <= cdb_en_d;
            cdb_tag_q  <= cdb_tag_d;
            cdb_data_q <= cdb_data_d;
            cdb_src_q  <= cdb_src_d;
        end
    end

    // Storage needs no reset: enq is already gated off while reset_i is high.
    always_ff @(posedge clk_i) begin
        for (int unsigned s = 0; s < NSRC; s++) begin
            if (enq[s]) begin
                mem_q[s][wr_ptr_q[s]] <= in_ent[s];
            end
        end
    end

    assign cdb_en_o   = cdb_en_q;
    assign cdb_tag_o  = cdb_tag_q;
    assign cdb_data_o = cdb_data_q;
    assign cdb_src_o  = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: per-source scoreboards filled on acceptance,
// drained by a CDB monitor; scenario tasks check timing, ordering and fairness inline.
module tb_cdb_arbiter;

    localparam int unsigned TAG_W  = 5;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              alu_valid, mul_valid, lsu_valid;
    logic [TAG_W-1:0]  alu_tag, mul_tag, lsu_tag;
    logic [DATA_W-1:0] alu_data, mul_data, lsu_data;
    logic              alu_ready, mul_ready, lsu_ready;
    logic              cdb_en;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic [1:0]        cdb_src;

    int checks = 0;
    int errors = 0;

    logic [TAG_W+DATA_W-1:0] sb0[$], sb1[$], sb2[$];
    int unsigned             acc_cnt [3] = '{0, 0, 0};
    logic [1:0]              log_src[$];
    logic [TAG_W-1:0]        log_tag[$];

    cdb_arbiter #(.FIFO_DEPTH(2), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk), .reset_i(reset),
        .alu_valid_i(alu_valid), .alu_tag_i(alu_tag), .alu_data_i(alu_data), .alu_ready_o(alu_ready),
        .mul_valid_i(mul_valid), .mul_tag_i(mul_tag), .mul_data_i(mul_data), .mul_ready_o(mul_ready),
        .lsu_valid_i(lsu_valid), .lsu_tag_i(lsu_tag), .lsu_data_i(lsu_data), .lsu_ready_o(lsu_ready),
        .cdb_en_o(cdb_en), .cdb_tag_o(cdb_tag), .cdb_data_o(cdb_data), .cdb_src_o(cdb_src)
    );

    always #5 clk = ~clk;

    // Inputs only change exactly at negedge; valid&ready here is what the next posedge samples.
    always @(negedge clk) begin
        #1;
        if (alu_valid && alu_ready) begin sb0.push_back({alu_tag, alu_data}); acc_cnt[0]++; end
        if (mul_valid && mul_ready) begin sb1.push_back({mul_tag, mul_data}); acc_cnt[1]++; end
        if (lsu_valid && lsu_ready) begin sb2.push_back({lsu_tag, lsu_data}); acc_cnt[2]++; end
    end

    always @(negedge clk) begin
        logic [TAG_W+DATA_W-1:0] exp_ent;
        logic                    have;
        if (cdb_en === 1'b1) begin
            log_src.push_back(cdb_src);
            log_tag.push_back(cdb_tag);
            have = 1'b1;
            exp_ent = '0;
            case (cdb_src)
                2'd0: if (sb0.size() > 0) exp_ent = sb0.pop_front(); else have = 1'b0;
                2'd1: if (sb1.size() > 0) exp_ent = sb1.pop_front(); else have = 1'b0;
                2'd2: if (sb2.size() > 0) exp_ent = sb2.pop_front(); else have = 1'b0;
                default: have = 1'b0;
            endcase
            checks++;
            if (!have) begin
                errors++;
                $display("FAIL sb_unexpected: broadcast src=%0d tag=%0d with no pending result", cdb_src, cdb_tag);
            end else if ({cdb_tag, cdb_data} !== exp_ent) begin
                errors++;
                $display("FAIL sb_entry: src=%0d got tag=%0d data=%h expected tag=%0d data=%h",
                         cdb_src, cdb_tag, cdb_data, exp_ent[TAG_W+DATA_W-1:DATA_W], exp_ent[DATA_W-1:0]);
            end
        end
    end

    task automatic drive_auto(input logic [2:0] en);
        alu_valid = en[0]; alu_tag = TAG_W'(acc_cnt[0]);      alu_data = 32'hA000_0000 | acc_cnt[0];
        mul_valid = en[1]; mul_tag = TAG_W'(8 + acc_cnt[1]);  mul_data = 32'hB100_0000 | acc_cnt[1];
        lsu_valid = en[2]; lsu_tag = TAG_W'(16 + acc_cnt[2]); lsu_data = 32'hC200_0000 | acc_cnt[2];
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        drive_auto(3'b000);
        repeat (n) @(negedge clk);
        reset = 1'b0;
        sb0.delete(); sb1.delete(); sb2.delete();
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        drive_auto(3'b000);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #2;
            if (sb0.size() == 0 && sb1.size() == 0 && sb2.size() == 0) break;
        end
        checks++;
        if (sb0.size() + sb1.size() + sb2.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d results never broadcast, expected 0",
                     name, sb0.size() + sb1.size() + sb2.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        alu_valid = 1'b1; alu_tag = 5'd1; alu_data = 32'h1;
        mul_valid = 1'b1; mul_tag = 5'd2; mul_data = 32'h2;
        lsu_valid = 1'b1; lsu_tag = 5'd3; lsu_data = 32'h3;
        repeat (2) begin
            @(negedge clk);
            checks += 4;
            if ({alu_ready, mul_ready, lsu_ready} !== 3'b000) begin
                errors += 3;
                $display("FAIL reset_ready: got %b expected 000", {alu_ready, mul_ready, lsu_ready});
            end
            if (cdb_en !== 1'b0) begin errors++; $display("FAIL reset_cdb_en: got %b expected 0", cdb_en); end
        end
        checks += 2;
        if (cdb_tag !== '0 || cdb_data !== '0) begin
            errors++; $display("FAIL reset_cdb_tagdata: got tag=%0d data=%h expected 0/0", cdb_tag, cdb_data);
        end
        if (cdb_src !== 2'd0) begin errors++; $display("FAIL reset_cdb_src: got %0d expected 0", cdb_src); end
        reset = 1'b0;
        drive_auto(3'b000);
        sb0.delete(); sb1.delete(); sb2.delete();
        #1;
        checks++;
        if ({alu_ready, mul_ready, lsu_ready} !== 3'b111) begin
            errors++; $display("FAIL post_reset_ready: got %b expected 111", {alu_ready, mul_ready, lsu_ready});
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (cdb_en !== 1'b0) begin errors++; $display("FAIL post_reset_idle: cdb_en got %b expected 0", cdb_en); end
        end
    endtask

    task automatic test_simultaneous;
        @(negedge clk);
        alu_valid = 1'b1; alu_tag = 5'd1; alu_data = 32'h1111_1111;
        mul_valid = 1'b1; mul_tag = 5'd2; mul_data = 32'h2222_2222;
        lsu_valid = 1'b1; lsu_tag = 5'd3; lsu_data = 32'h3333_3333;
        @(negedge clk);
        drive_auto(3'b000);
        checks++;
        if (cdb_en !== 1'b0) begin errors++; $display("FAIL simul_early: cdb_en got %b expected 0", cdb_en); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (cdb_en !== 1'b1 || cdb_tag !== TAG_W'(k + 1) || cdb_src !== 2'(k)) begin
                errors++;
                $display("FAIL simul_%0d: got en=%b tag=%0d src=%0d expected en=1 tag=%0d src=%0d",
                         k, cdb_en, cdb_tag, cdb_src, k + 1, k);
            end
        end
        @(negedge clk);
        checks++;
        if (cdb_en !== 1'b0) begin errors++; $display("FAIL simul_after: cdb_en got %b expected 0", cdb_en); end
    endtask

    task automatic test_single;
        @(negedge clk);
        alu_valid = 1'b1; alu_tag = 5'd7; alu_data = 32'hDEAD_BEEF;
        @(negedge clk);
        drive_auto(3'b000);
        @(negedge clk);
        checks++;
        if (cdb_en !== 1'b1 || cdb_tag !== 5'd7 || cdb_data !== 32'hDEAD_BEEF || cdb_src !== 2'd0) begin
            errors++;
            $display("FAIL single: got en=%b tag=%0d data=%h src=%0d expected en=1 tag=7 data=deadbeef src=0",
                     cdb_en, cdb_tag, cdb_data, cdb_src);
        end
        @(negedge clk);
        checks++;
        if (cdb_en !== 1'b0) begin errors++; $display("FAIL single_pulse: cdb_en got %b expected 0", cdb_en); end
        if (cdb_tag !== 5'd7) begin
            checks++; errors++;
            $display("FAIL single_hold: cdb_tag got %0d expected 7 held", cdb_tag);
        end else checks++;
    endtask

    task automatic test_fairness;
        int base;
        int per_src [3];
        bit done;
        do_reset(1);
        #2;
        base = log_src.size();
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            drive_auto(3'b111);
            #2;
            if (log_src.size() >= base + 9) begin done = 1'b1; break; end
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL fair_timeout: got %0d grants expected 9", log_src.size() - base);
        end else begin
            per_src = '{0, 0, 0};
            for (int k = 0; k < 9; k++) begin
                checks++;
                per_src[log_src[base + k]]++;
                if (log_src[base + k] !== 2'(k % 3)) begin
                    errors++; $display("FAIL fair_seq_%0d: src got %0d expected %0d", k, log_src[base + k], k % 3);
                end
            end
            for (int s = 0; s < 3; s++) begin
                checks++;
                if (per_src[s] != 3) begin
                    errors++; $display("FAIL fair_count_%0d: got %0d grants expected 3", s, per_src[s]);
                end
            end
        end
        drain("fair");
    endtask

    task automatic test_backpressure;
        int base, mstart, mi, nmul;
        bit ready_checked, done;
        do_reset(1);
        #2;
        base = log_src.size();
        mstart = acc_cnt[1];
        ready_checked = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            mi = acc_cnt[1] - mstart;
            if (mi >= 3) begin done = 1'b1; break; end
            drive_auto(3'b101);
            mul_valid = 1'b1; mul_tag = TAG_W'(4 + mi); mul_data = 32'hB000_0000 | mi;
            if (mi == 2 && !ready_checked) begin
                ready_checked = 1'b1;
                checks++;
                if (mul_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_ready_low: mul_ready got %b expected 0 at count 2", mul_ready);
                end
            end
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL bp_accept6: MUL accepted %0d results expected 3", acc_cnt[1] - mstart);
        end
        drive_auto(3'b000);
        drain("bp");
        nmul = 0;
        for (int k = base; k < log_src.size(); k++) begin
            if (log_src[k] == 2'd1) begin
                checks++;
                if (log_tag[k] !== TAG_W'(4 + nmul)) begin
                    errors++; $display("FAIL bp_order_%0d: mul tag got %0d expected %0d", nmul, log_tag[k], 4 + nmul);
                end
                nmul++;
            end
        end
        checks++;
        if (nmul != 3) begin errors++; $display("FAIL bp_mul_count: got %0d MUL broadcasts expected 3", nmul); end
    endtask

    task automatic test_reset_midop;
        do_reset(1);
        repeat (4) begin
            @(negedge clk);
            drive_auto(3'b111);
        end
        @(negedge clk);
        reset = 1'b1;
        drive_auto(3'b000);
        @(negedge clk);
        reset = 1'b0;
        sb0.delete(); sb1.delete(); sb2.delete();
        checks++;
        if (cdb_en !== 1'b0) begin errors++; $display("FAIL midrst_en0: cdb_en got %b expected 0", cdb_en); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (cdb_en !== 1'b0) begin
                errors++; $display("FAIL midrst_idle_%0d: cdb_en got %b expected 0 (discarded)", i, cdb_en);
            end
        end
        @(negedge clk);
        drive_auto(3'b111);
        @(negedge clk);
        drive_auto(3'b000);
        @(negedge clk);
        checks++;
        if (cdb_en !== 1'b1 || cdb_src !== 2'd0) begin
            errors++; $display("FAIL midrst_first_alu: got en=%b src=%0d expected en=1 src=0", cdb_en, cdb_src);
        end
        drain("midrst");
    endtask

    initial begin
        test_reset;
        test_simultaneous;
        test_single;
        test_fairness;
        test_backpressure;
        test_reset_midop;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
